// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared register map and helpers for the output PIO
package pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int STATUS_BUSY_BIT = 0;

  // Down-counter width for a pulse of the given length; never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// rtl/pio_pulse_timer.sv - one-shot down-counter that times the pulse register
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int PULSE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic cancel_i,
  output logic busy_o,
  output logic expire_o
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  assign expire_o = busy_q && (count_q == '0);
  assign busy_o   = busy_q;

  // A load on the expiry edge wins: the caller has already retired the old bits.
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (load_i) begin
      count_d = LOAD_VAL;
      busy_d  = 1'b1;
    end else if (cancel_i || expire_o) begin
      count_d = '0;
      busy_d  = 1'b0;
    end else if (busy_q) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/button_pio_out.sv
// rtl/button_pio_out.sv - Avalon-MM output PIO with set/clear and self-clearing pulse bits
module button_pio_out
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0] data_e, mask_e;
  logic                  busy, expire, load, cancel, wr_en;

  pio_pulse_timer #(.PULSE_CYCLES(PULSE_CYCLES)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (load),
    .cancel_i (cancel),
    .busy_o   (busy),
    .expire_o (expire)
  );

  assign wr_en = chipselect && !write_n;

  // Expiry is retired first; any write this cycle then acts on the post-expiry state.
  assign data_e = expire ? (data_q & ~mask_q) : data_q;
  assign mask_e = expire ? '0 : mask_q;

  always_comb begin
    data_d = data_e;
    mask_d = mask_e;
    load   = 1'b0;
    cancel = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          data_d = writedata;
          mask_d = '0;
          cancel = 1'b1;
        end
        ADDR_SET: begin
          data_d = data_e | writedata;
          mask_d = mask_e & ~writedata;
        end
        ADDR_CLR: begin
          data_d = data_e & ~writedata;
          mask_d = mask_e & ~writedata;
          cancel = (mask_d == '0);
        end
        ADDR_PULSE: begin
          if (writedata != '0) begin
            data_d = data_e | writedata;
            mask_d = mask_e | writedata;
            load   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d = data_q;
      ADDR_PULSE:  readdata_d = mask_q;
      ADDR_STATUS: readdata_d[STATUS_BUSY_BIT] = busy;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port = data_q;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_button_pio_out.sv
// tb/tb_button_pio_out.sv - scoreboard bench for button_pio_out against a deadline-based model
module tb_button_pio_out;

  localparam int             DW = 12;
  localparam int             P  = 4;
  localparam logic [DW-1:0]  RV = 12'h000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic [DW-1:0] out_port;

  always #5 clk = ~clk;

  button_pio_out #(
    .DATA_WIDTH   (DW),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (P)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  typedef struct {
    logic [DW-1:0] out;
    logic [DW-1:0] rd;
    int            edge_no;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: pending pulse bits expire together at an absolute edge number.
  logic [DW-1:0] m_data = RV;
  logic [DW-1:0] m_mask = '0;
  bit            m_busy = 1'b0;
  int            m_deadline = 0;
  int            edge_n = 0;

  task automatic check(input string name, input int edge_no,
                       input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %03h, expected %03h", name, edge_no, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit cs, input bit wn,
                      input logic [2:0] a, input logic [DW-1:0] wd);
    exp_t          e;
    logic [DW-1:0] rd;
    @(negedge clk);
    #1;
    reset_n    = !rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    edge_n++;
    if (rst) begin
      m_data = RV;
      m_mask = '0;
      m_busy = 1'b0;
      rd     = '0;
    end else begin
      case (a)
        3'd0:    rd = m_data;
        3'd3:    rd = m_mask;
        3'd4:    rd = {{(DW-1){1'b0}}, m_busy};
        default: rd = '0;
      endcase
      if (m_busy && edge_n == m_deadline) begin
        m_data = m_data & ~m_mask;
        m_mask = '0;
        m_busy = 1'b0;
      end
      if (cs && !wn) begin
        case (a)
          3'd0: begin
            m_data = wd;
            m_mask = '0;
            m_busy = 1'b0;
          end
          3'd1: begin
            m_data = m_data | wd;
            m_mask = m_mask & ~wd;
          end
          3'd2: begin
            m_data = m_data & ~wd;
            m_mask = m_mask & ~wd;
            if (m_mask == '0) m_busy = 1'b0;
          end
          3'd3: begin
            if (wd != '0) begin
              m_data     = m_data | wd;
              m_mask     = m_mask | wd;
              m_busy     = 1'b1;
              m_deadline = edge_n + P;
            end
          end
          default: ;
        endcase
      end
    end
    e.out     = m_data;
    e.rd      = rd;
    e.edge_no = edge_n;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] wd);
    step(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, 1'b0, 1'b1, a, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_port", e.edge_no, out_port, e.out);
        check("readdata", e.edge_no, readdata, e.rd);
      end
    end
  end

  initial begin : driver
    logic [DW-1:0] wd;
    bit            cs, wn, rst;
    logic [2:0]    a;

    step(1'b1, 1'b0, 1'b1, 3'd0, '0);
    step(1'b1, 1'b0, 1'b1, 3'd0, '0);
    #1;
    check("reset_out_port", edge_n, out_port, RV);
    check("reset_readdata", edge_n, readdata, '0);
    rd(3'd4);
    rd(3'd4);

    wr(3'd0, 12'hA5A);
    rd(3'd0);
    rd(3'd0);
    wr(3'd1, 12'h005);
    wr(3'd2, 12'h00F);
    rd(3'd0);

    wr(3'd0, 12'h000);
    wr(3'd3, 12'h003);
    repeat (5) rd(3'd4);
    rd(3'd3);

    wr(3'd3, 12'h001);
    rd(3'd4);
    wr(3'd3, 12'h002);
    repeat (6) rd(3'd3);

    wr(3'd3, 12'h001);
    repeat (3) rd(3'd4);
    wr(3'd1, 12'h001);
    rd(3'd4);
    rd(3'd0);

    wr(3'd0, 12'h000);
    wr(3'd3, 12'h001);
    rd(3'd4);
    wr(3'd0, 12'h800);
    rd(3'd4);
    rd(3'd0);

    wr(3'd0, 12'h000);
    wr(3'd3, 12'h001);
    rd(3'd4);
    step(1'b1, 1'b0, 1'b1, 3'd4, '0);
    #1;
    check("async_reset_out_port", edge_n, out_port, RV);
    check("async_reset_readdata", edge_n, readdata, '0);
    rd(3'd4);
    rd(3'd4);

    wr(3'd3, 12'h000);
    wr(3'd5, 12'hFFF);
    wr(3'd4, 12'hFFF);
    rd(3'd5);
    rd(3'd1);
    rd(3'd0);

    repeat (2000) begin
      rst = ($urandom_range(0, 299) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      wn  = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       wd = '0;
        1:       wd = DW'(1) << $urandom_range(0, DW - 1);
        default: wd = DW'($urandom);
      endcase
      step(rst, cs, wn, a, wd);
    end

    rd(3'd0);
    rd(3'd4);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
